half_pwm_burst_ctrl: RTL and testbench

HALF_PWM_BURST_CTRL -- requirements
Module: half_pwm_burst_ctrl

---
 rtl/half_pwm_burst_ctrl.sv | 157 +++++++++++++++
 tb/tb_half_pwm_burst_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/half_pwm_burst_ctrl.sv
// Burst sequencer for half_pwm_die: issues a configured number of one-cycle starts, each
// released by a completion rise plus an optional idle gap. HALF_PWM_BURST_WDT_EN adds a WAIT watchdog.
module half_pwm_burst_ctrl #(
  parameter int unsigned _RAM_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned WDT_CYCLES = 1000000
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CNT_WIDTH-1:0]  cfg_burst_count,
  input  logic [_RAM_WIDTH-1:0] cfg_gap,
  input  logic [_RAM_WIDTH-1:0] cfg_die_period,
  input  logic [_RAM_WIDTH-1:0] cfg_pulse_period,
  input  logic                  abort,
  input  logic                  pulse_valid,
  output logic                  pwm_start,
  output logic                  pwm_dis,
  output logic [_RAM_WIDTH-1:0] die_period,
  output logic [_RAM_WIDTH-1:0] pulse_period,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pulse_idx,
  output logic                  burst_done,
  output logic                  burst_aborted,
  output logic                  wdt_fault
);

  typedef enum logic [2:0] {IDLE, START, WAIT, GAP, DONE, ABORT} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  count;
  logic [_RAM_WIDTH-1:0] gap;
  logic [_RAM_WIDTH-1:0] gap_cnt;
  logic                  pv_q;
  logic                  rise_c;
  logic [CNT_WIDTH-1:0]  idx_inc_c;

  assign rise_c    = pulse_valid & ~pv_q;
  assign idx_inc_c = pulse_idx + CNT_WIDTH'(1);

`ifdef HALF_PWM_BURST_WDT_EN
  localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_hit_c;
  assign wdt_hit_c = (32'(wdt_cnt) == WDT_CYCLES - 1);
`else
  // Without the watchdog the limit has no effect.
  logic unused_wdt;
  assign unused_wdt = |WDT_CYCLES;
  assign wdt_fault  = 1'b0;
`endif

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state         <= IDLE;
      cfg_ready     <= 1'b0;
      busy          <= 1'b0;
      pwm_start     <= 1'b0;
      pwm_dis       <= 1'b0;
      burst_done    <= 1'b0;
      burst_aborted <= 1'b0;
      die_period    <= '0;
      pulse_period  <= '0;
      pulse_idx     <= '0;
      count         <= '0;
      gap           <= '0;
      gap_cnt       <= '0;
      pv_q          <= 1'b0;
`ifdef HALF_PWM_BURST_WDT_EN
      wdt_fault     <= 1'b0;
      wdt_cnt       <= '0;
`endif
    end else begin
      pv_q          <= pulse_valid;
      pwm_start     <= 1'b0;
      pwm_dis       <= 1'b0;
      burst_done    <= 1'b0;
      burst_aborted <= 1'b0;
`ifdef HALF_PWM_BURST_WDT_EN
      wdt_fault     <= 1'b0;
`endif
      // Abort outranks a same-cycle rise or gap expiry; pulse_idx is left untouched.
      if (abort && state != IDLE && state != ABORT) begin
        state <= ABORT;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            if (cfg_valid && cfg_ready) begin
              cfg_ready    <= 1'b0;
              busy         <= 1'b1;
              count        <= cfg_burst_count;
              gap          <= cfg_gap;
              die_period   <= cfg_die_period;
              pulse_period <= cfg_pulse_period;
              pulse_idx    <= '0;
              state        <= (cfg_burst_count == '0) ? DONE : START;
            end else begin
              cfg_ready <= 1'b1;
            end
          end
          START: begin
            pwm_start <= 1'b1;
            state     <= WAIT;
`ifdef HALF_PWM_BURST_WDT_EN
            wdt_cnt   <= '0;
`endif
          end
          WAIT: begin
            if (rise_c) begin
              pulse_idx <= idx_inc_c;
              if (idx_inc_c == count) begin
                state <= DONE;
              end else if (gap == '0) begin
                state <= START;
              end else begin
                state   <= GAP;
                gap_cnt <= gap;
              end
            end
`ifdef HALF_PWM_BURST_WDT_EN
            else if (wdt_hit_c) begin
              wdt_fault <= 1'b1;
              state     <= ABORT;
            end else begin
              wdt_cnt <= wdt_cnt + WDT_W'(1);
            end
`endif
          end
          GAP: begin
            if (gap_cnt == _RAM_WIDTH'(1)) begin
              state <= START;
            end else begin
              gap_cnt <= gap_cnt - _RAM_WIDTH'(1);
            end
          end
          DONE: begin
            burst_done <= 1'b1;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
            state      <= IDLE;
          end
          ABORT: begin
            pwm_dis       <= 1'b1;
            burst_aborted <= 1'b1;
            busy          <= 1'b0;
            cfg_ready     <= 1'b1;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_half_pwm_burst_ctrl.sv
// Scoreboard bench for half_pwm_burst_ctrl: bursts are planned as edge-time schedules,
// expected strobes are queued, and a negedge monitor pops and compares them.
module tb_half_pwm_burst_ctrl;

  localparam int TB_WDT = 50;
  localparam logic [4:0] EV_START = 5'b00001;
  localparam logic [4:0] EV_DONE  = 5'b00010;
  localparam logic [4:0] EV_ABORT = 5'b01100;
  localparam logic [4:0] EV_WDT   = 5'b10000;

  logic        io_clk = 1'b0;
  logic        io_rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_burst_count;
  logic [31:0] cfg_gap;
  logic [31:0] cfg_die_period;
  logic [31:0] cfg_pulse_period;
  logic        abort;
  logic        pulse_valid;
  logic        pwm_start;
  logic        pwm_dis;
  logic [31:0] die_period;
  logic [31:0] pulse_period;
  logic        busy;
  logic [15:0] pulse_idx;
  logic        burst_done;
  logic        burst_aborted;
  logic        wdt_fault;

  half_pwm_burst_ctrl #(
    ._RAM_WIDTH(32),
    .CNT_WIDTH (16),
    .WDT_CYCLES(TB_WDT)
  ) dut (
    .io_clk          (io_clk),
    .io_rst          (io_rst),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_burst_count (cfg_burst_count),
    .cfg_gap         (cfg_gap),
    .cfg_die_period  (cfg_die_period),
    .cfg_pulse_period(cfg_pulse_period),
    .abort           (abort),
    .pulse_valid     (pulse_valid),
    .pwm_start       (pwm_start),
    .pwm_dis         (pwm_dis),
    .die_period      (die_period),
    .pulse_period    (pulse_period),
    .busy            (busy),
    .pulse_idx       (pulse_idx),
    .burst_done      (burst_done),
    .burst_aborted   (burst_aborted),
    .wdt_fault       (wdt_fault)
  );

  always #5 io_clk = ~io_clk;

  // Edge number of the most recent rising edge.
  int cyc = 0;
  always @(posedge io_clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_no;
    logic [4:0]  kind;
    int          idx;
    logic [31:0] dp;
    logic [31:0] pp;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [86:0] outs;
  assign outs = {cfg_ready, busy, pwm_start, pwm_dis, burst_done, burst_aborted, wdt_fault,
                 pulse_idx, die_period, pulse_period};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge io_clk) begin
    ev_t        e;
    logic [4:0] obs;
    obs = {wdt_fault, pwm_dis, burst_aborted, burst_done, pwm_start};
    while (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missed_event: kind %b due at edge %0d, absent at edge %0d", e.kind, e.edge_no, cyc);
    end
    if (obs != 5'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: kind %b at edge %0d, required none", obs, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event {edge,kind,idx,die,pulse}",
            128'({32'(cyc), obs, pulse_idx, die_period, pulse_period}),
            128'({32'(e.edge_no), e.kind, 16'(e.idx), e.dp, e.pp}));
      end
    end
  end

  // mode: 0 normal, 1 abort, 2 reset in GAP, 3 first completion never arrives.
  // Called at a negedge while idle; the request is accepted at the next rising edge.
  task automatic run_burst(input int cnt, input int gp, input int mode, input int lat, input int ab_rise);
    int          a, d, cut, last, endb, nr, l;
    int          s[$];
    int          r[$];
    logic [31:0] dp, pp;
    bit          hold, pv;
    a    = cyc + 1;
    dp   = $urandom;
    pp   = $urandom;
    hold = 1'($urandom_range(0, 1));
    for (int k = 0; k < cnt; k++) begin
      s.push_back(k == 0 ? a + 1 : r[k-1] + gp + 1);
      l = (lat > 0) ? lat : int'($urandom_range(1, 6));
      if (mode == 3 && k == 0) l = 100000;
      r.push_back(s[k] + l);
    end
    d   = (cnt == 0) ? a + 1 : r[cnt-1] + 1;
    cut = 32'h3fff_ffff;
    if (mode == 1) begin
      if (ab_rise > 0) cut = r[ab_rise-1];
      else if (cnt > 0 && $urandom_range(0, 1) == 1) cut = r[$urandom_range(0, cnt - 1)];
      else cut = int'($urandom_range(d, a + 1));
    end else if (mode == 2) begin
      cut = r[0] + 2;
    end else if (mode == 3) begin
      cut = s[0] + TB_WDT;
    end
    nr = 0;
    foreach (r[k]) if (r[k] < cut) nr++;
    foreach (s[k]) if (s[k] < cut) exp_q.push_back('{s[k], EV_START, k, dp, pp});
    case (mode)
      0: begin exp_q.push_back('{d, EV_DONE, cnt, dp, pp}); last = d; end
      1: begin exp_q.push_back('{cut + 1, EV_ABORT, nr, dp, pp}); last = cut + 1; end
      2: last = cut + 2;
      default: begin
        exp_q.push_back('{cut, EV_WDT, nr, dp, pp});
        exp_q.push_back('{cut + 1, EV_ABORT, nr, dp, pp});
        last = cut + 1;
      end
    endcase
    endb = (mode == 2) ? cut : last;

    cfg_valid        = 1'b1;
    cfg_burst_count  = 16'(cnt);
    cfg_gap          = 32'(gp);
    cfg_die_period   = dp;
    cfg_pulse_period = pp;
    pulse_valid      = 1'b0;
    abort            = 1'b0;
    chk("ready_before_accept", 128'({cfg_ready, busy}), 128'(2'b10));
    do begin
      @(negedge io_clk);
      if (cyc == a)
        chk("accepted", 128'({cfg_ready, busy, pulse_idx, die_period, pulse_period}),
            128'({1'b0, 1'b1, 16'd0, dp, pp}));
      if (cyc == endb - 1 && cyc > a)
        chk("no_relatch", 128'({cfg_ready, busy, die_period, pulse_period}), 128'({1'b0, 1'b1, dp, pp}));
      if (mode == 2 && (cyc == cut || cyc == cut + 1))
        chk("reset_zero", 128'(outs), 128'(0));
      if (cyc < last) begin
        pv = 1'b0;
        foreach (r[k]) if (r[k] == cyc + 1 && (r[k] < cut || mode == 1)) pv = 1'b1;
        pulse_valid = pv;
        abort       = (mode == 1 && cyc + 1 == cut);
        io_rst      = (mode == 2 && (cyc + 1 == cut || cyc + 1 == cut + 1));
        if (cyc == a) begin
          cfg_valid        = hold;
          cfg_burst_count  = 16'($urandom);
          cfg_gap          = $urandom;
          cfg_die_period   = $urandom;
          cfg_pulse_period = $urandom;
        end
      end
    end while (cyc < last);
    cfg_valid   = 1'b0;
    pulse_valid = 1'b0;
    abort       = 1'b0;
    io_rst      = 1'b0;
  endtask

  // Idle cycles with abort and completion noise, both of which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      cfg_valid   = 1'b0;
      abort       = 1'($urandom);
      pulse_valid = 1'($urandom);
      @(negedge io_clk);
      chk("idle_state", 128'({cfg_ready, busy}), 128'(2'b10));
    end
    abort       = 1'b0;
    pulse_valid = 1'b0;
  endtask

  initial begin
    io_rst           = 1'b1;
    cfg_valid        = 1'b0;
    cfg_burst_count  = '0;
    cfg_gap          = '0;
    cfg_die_period   = '0;
    cfg_pulse_period = '0;
    abort            = 1'b0;
    pulse_valid      = 1'b0;
    repeat (3) @(negedge io_clk);
    chk("reset_outputs", 128'(outs), 128'(0));
    io_rst = 1'b0;
    @(negedge io_clk);

    run_burst(3, 0, 0, 5, 0);
    run_burst(2, 4, 0, 0, 0);
    run_burst(0, 0, 0, 0, 0);
    run_burst(5, 2, 1, 0, 2);
    run_burst(3, 6, 2, 0, 0);
`ifdef HALF_PWM_BURST_WDT_EN
    run_burst(2, 1, 3, 0, 0);
`endif
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)));
      run_burst(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                ($urandom_range(0, 9) < 3) ? 1 : 0, 0, 0);
    end
    idle(5);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
